// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite channel bundle between the command master and the crossbar port.
// Every channel transfers on a clock edge where its valid and ready are both high; valid never drops before that.
interface axi_lite_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]            aw_prot;
  logic                  aw_valid;
  logic                  aw_ready;

  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;

  logic                  b_valid;
  logic [1:0]            b_resp;
  logic                  b_ready;

  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]            ar_prot;
  logic                  ar_valid;
  logic                  ar_ready;

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_ready;

  modport master (
    output aw_addr, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_valid,
    input  w_ready,
    input  b_valid, b_resp,
    output b_ready,
    output ar_addr, ar_prot, ar_valid,
    input  ar_ready,
    input  r_valid, r_data, r_resp,
    output r_ready
  );

  modport slave (
    input  aw_addr, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_valid,
    output w_ready,
    output b_valid, b_resp,
    input  b_ready,
    input  ar_addr, ar_prot, ar_valid,
    output ar_ready,
    output r_valid, r_data, r_resp,
    input  r_ready
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-beat command/response front end that issues one AXI4-Lite read or write at a time.
// Responses come back in command order; AXI error codes are passed through untouched.
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic                    cmd_we_i,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic                    rsp_we_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]              rsp_resp_o,
  output logic [2:0]              dbg_state_o,
  axi_lite_cmd_master_if.master   master
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                  state_q;
  state_t                  state_d;

  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    aw_done_q;
  logic                    w_done_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [1:0]              resp_q;

  logic cmd_hs;
  logic aw_hs;
  logic w_hs;
  logic b_hs;
  logic r_hs;

  assign cmd_hs = cmd_valid_i & cmd_ready_o;
  assign aw_hs  = master.aw_valid & master.aw_ready;
  assign w_hs   = master.w_valid & master.w_ready;
  assign b_hs   = master.b_valid & master.b_ready;
  assign r_hs   = master.r_valid & master.r_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    cmd_ready_o     = 1'b0;
    rsp_valid_o     = 1'b0;
    master.aw_valid = 1'b0;
    master.w_valid  = 1'b0;
    master.b_ready  = 1'b0;
    master.ar_valid = 1'b0;
    master.r_ready  = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          state_d = cmd_we_i ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        // AW and W retire independently; leave once both have been accepted.
        master.aw_valid = ~aw_done_q;
        master.w_valid  = ~w_done_q;
        if ((aw_done_q | master.aw_ready) & (w_done_q | master.w_ready)) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        master.b_ready = 1'b1;
        if (master.b_valid) begin
          state_d = RSP;
        end
      end
      RD_REQ: begin
        master.ar_valid = 1'b1;
        if (master.ar_ready) begin
          state_d = RD_RESP;
        end
      end
      RD_RESP: begin
        master.r_ready = 1'b1;
        if (master.r_valid) begin
          state_d = RSP;
        end
      end
      RSP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
    end else begin
      if (cmd_hs) begin
        we_q      <= cmd_we_i;
        addr_q    <= cmd_addr_i;
        wdata_q   <= cmd_wdata_i;
        wstrb_q   <= cmd_wstrb_i;
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
      end
      if (aw_hs) begin
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        w_done_q <= 1'b1;
      end
      // Writes report zero read data so the response word is fully defined.
      if (b_hs) begin
        resp_q  <= master.b_resp;
        rdata_q <= '0;
      end
      if (r_hs) begin
        resp_q  <= master.r_resp;
        rdata_q <= master.r_data;
      end
    end
  end

  assign master.aw_addr = addr_q;
  assign master.aw_prot = 3'b000;
  assign master.w_data  = wdata_q;
  assign master.w_strb  = wstrb_q;
  assign master.ar_addr = addr_q;
  assign master.ar_prot = 3'b000;

  assign rsp_we_o    = we_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_resp_o  = resp_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: delay-programmable AXI slave with a small RAM,
// and a memory-level reference model that predicts every response and its cycle timing.
module tb_axi_lite_cmd_master;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int SW        = DW / 8;
  localparam int RAM_WORDS = 1024;
  localparam int EW        = 1 + 2 + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_we;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [2:0]    dbg_state;

  axi_lite_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi_lite_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_addr_i  (cmd_addr),
    .cmd_wdata_i (cmd_wdata),
    .cmd_wstrb_i (cmd_wstrb),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_we_o    (rsp_we),
    .rsp_rdata_o (rsp_rdata),
    .rsp_resp_o  (rsp_resp),
    .dbg_state_o (dbg_state),
    .master      (axi)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] model_mem[RAM_WORDS];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a flat word RAM below 4 KiB, DECERR everywhere else.
  function automatic logic [EW-1:0] model_txn(input logic we, input logic [AW-1:0] addr,
                                              input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
    logic   mapped;
    int     idx;
    mapped = (addr < AW'(RAM_WORDS * 4));
    idx    = int'(addr[11:2]);
    if (we) begin
      if (mapped) begin
        for (int i = 0; i < SW; i++) begin
          if (strb[i]) model_mem[idx][8*i +: 8] = wdata[8*i +: 8];
        end
      end
      return {1'b1, (mapped ? 2'b00 : 2'b11), {DW{1'b0}}};
    end
    return {1'b0, (mapped ? 2'b00 : 2'b11), (mapped ? model_mem[idx] : 32'hDEC0_DEC0)};
  endfunction

  // ---------------- AXI slave ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw_beats = 0, w_beats = 0, ar_beats = 0;
  bit aw_have = 0, w_have = 0, ar_have = 0;
  logic [AW-1:0] cap_awaddr, cap_araddr;
  logic [DW-1:0] cap_wdata;
  logic [SW-1:0] cap_wstrb;
  logic [DW-1:0] slv_mem[RAM_WORDS];

  task automatic slave_step();
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
    axi.b_valid = 1'b0;  axi.b_resp = 2'b00;
    axi.r_valid = 1'b0;  axi.r_resp = 2'b00; axi.r_data = '0;
    if (rst) begin
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      aw_have = 0; w_have = 0; ar_have = 0;
      return;
    end
    if (axi.b_ready && aw_have && w_have) begin
      if (b_cnt >= b_dly) begin
        axi.b_valid = 1'b1;
        if (cap_awaddr < AW'(RAM_WORDS * 4)) begin
          for (int i = 0; i < SW; i++)
            if (cap_wstrb[i]) slv_mem[cap_awaddr[11:2]][8*i +: 8] = cap_wdata[8*i +: 8];
        end else begin
          axi.b_resp = 2'b11;
        end
        aw_have = 0; w_have = 0; b_cnt = 0;
      end else b_cnt++;
    end
    if (axi.r_ready && ar_have) begin
      if (r_cnt >= r_dly) begin
        axi.r_valid = 1'b1;
        if (cap_araddr < AW'(RAM_WORDS * 4)) axi.r_data = slv_mem[cap_araddr[11:2]];
        else begin axi.r_data = 32'hDEC0_DEC0; axi.r_resp = 2'b11; end
        ar_have = 0; r_cnt = 0;
      end else r_cnt++;
    end
    if (axi.aw_valid) begin
      if (aw_cnt >= aw_dly) begin
        axi.aw_ready = 1'b1; aw_cnt = 0; aw_beats++; cap_awaddr = axi.aw_addr; aw_have = 1;
      end else aw_cnt++;
    end else aw_cnt = 0;
    if (axi.w_valid) begin
      if (w_cnt >= w_dly) begin
        axi.w_ready = 1'b1; w_cnt = 0; w_beats++;
        cap_wdata = axi.w_data; cap_wstrb = axi.w_strb; w_have = 1;
      end else w_cnt++;
    end else w_cnt = 0;
    if (axi.ar_valid) begin
      if (ar_cnt >= ar_dly) begin
        axi.ar_ready = 1'b1; ar_cnt = 0; ar_beats++; cap_araddr = axi.ar_addr; ar_have = 1;
      end else ar_cnt++;
    end else ar_cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < RAM_WORDS; i++) begin
      slv_mem[i]   = '0;
      model_mem[i] = '0;
    end
    axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
    axi.b_valid = 1'b0;  axi.b_resp = 2'b00;
    axi.r_valid = 1'b0;  axi.r_resp = 2'b00; axi.r_data = '0;
    forever begin
      @(posedge clk);
      #1;
      slave_step();
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [6:0] bus_activity();
    return {axi.aw_valid, axi.w_valid, axi.b_ready, axi.ar_valid, axi.r_ready, rsp_valid, cmd_ready};
  endfunction

  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input logic [SW-1:0] strb, input int da, input int dw, input int db,
                         input int dar, input int dr, input int hold, input bit pend_next);
    int cyc, exp_lat, mx;
    logic [EW-1:0] exp_rsp;
    logic [4:0] exp_ch;
    aw_dly = da; w_dly = dw; b_dly = db; ar_dly = dar; r_dly = dr;
    exp_q.push_back(model_txn(we, addr, wdata, strb));
    mx      = (da > dw) ? da : dw;
    exp_lat = we ? (3 + mx + db) : (3 + dar + dr);
    aw_beats = 0; w_beats = 0; ar_beats = 0;
    cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb; cmd_valid = 1'b1;
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check("cmd_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_we = 1'($urandom_range(0, 1)); cmd_addr = $urandom; cmd_wdata = $urandom;
    cyc = 1;
    while (!rsp_valid && cyc < 100) begin
      exp_ch = {we && cyc <= 1 + da, we && cyc <= 1 + dw,
                we && cyc >= 2 + mx && cyc <= 2 + mx + db,
                !we && cyc <= 1 + dar, !we && cyc >= 2 + dar && cyc <= 2 + dar + dr};
      check("axi_timeline", {cyc[7:0], axi.aw_valid, axi.w_valid, axi.b_ready, axi.ar_valid, axi.r_ready},
            {cyc[7:0], exp_ch});
      if (axi.aw_valid) check("aw_addr", axi.aw_addr, addr);
      if (axi.w_valid)  check("w_data_strb", {axi.w_strb, axi.w_data}, {strb, wdata});
      if (axi.ar_valid) check("ar_addr", axi.ar_addr, addr);
      check("prot_and_busy", {axi.aw_prot, axi.ar_prot, cmd_ready}, 7'b0);
      @(posedge clk); #1; cyc++;
    end
    check("rsp_latency", cyc, exp_lat);
    check("beats", {aw_beats[7:0], w_beats[7:0], ar_beats[7:0]},
          we ? 24'h010100 : 24'h000001);
    exp_rsp = exp_q.pop_front();
    check("rsp_fields", {rsp_we, rsp_resp, rsp_rdata}, exp_rsp);
    if (pend_next) begin
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'h0000_0010; cmd_wdata = '0; cmd_wstrb = '1;
    end
    repeat (hold) begin
      @(posedge clk); #1;
      check("rsp_hold", {rsp_valid, rsp_we, rsp_resp, rsp_rdata}, {1'b1, exp_rsp});
      check("hold_no_axi", bus_activity(), 7'b0000010);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_rsp", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  // ---------------- directed + random sequence ----------------
  logic          r_we;
  logic [AW-1:0] r_addr;

  initial begin
    #1 rst = 1'b1;
    #2;
    check("reset_ctrl", bus_activity(), 7'b0000001);
    check("reset_rsp", {rsp_we, rsp_resp, rsp_rdata}, '0);
    check("reset_addr", {axi.aw_addr, axi.ar_addr}, '0);
    check("reset_wdata", {axi.w_strb, axi.w_data}, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", bus_activity(), 7'b0000001);

    // zero-wait write, then W ahead of AW by three cycles
    run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 0, 1'b0);
    run_txn(1'b1, 32'h0000_0020, 32'h1234_5678, 4'h5, 3, 0, 0, 0, 0, 0, 1'b0);
    // read back with slow AR and R
    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 0, 2, 4, 0, 1'b0);
    // unmapped read and write, then a normal read
    run_txn(1'b0, 32'hF000_0000, 32'h0, 4'h0, 0, 0, 0, 1, 0, 0, 1'b0);
    run_txn(1'b1, 32'h8000_0040, 32'h5555_AAAA, 4'hF, 0, 1, 2, 0, 0, 1, 1'b0);
    run_txn(1'b0, 32'h0000_0020, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1'b0);
    // consumer stall for 10 cycles with the next command already waiting
    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 1, 10, 1'b1);
    run_txn(1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, 1, 1, 0, 0, 0, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1'b0);

    // reset while AW/W are pending
    aw_dly = 40; w_dly = 40;
    cmd_we = 1'b1; cmd_addr = 32'h0000_0040; cmd_wdata = 32'h0BAD_0BAD; cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("pending_write", {axi.aw_valid, axi.w_valid}, 2'b11);
    #3 rst = 1'b1;
    #1;
    check("async_reset_ctrl", bus_activity(), 7'b0000001);
    check("async_reset_rsp", {rsp_we, rsp_resp, rsp_rdata}, '0);
    check("async_reset_bus", {axi.aw_addr, axi.w_strb, axi.w_data}, '0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", bus_activity(), 7'b0000001);
    run_txn(1'b1, 32'h0000_0040, 32'h0123_4567, 4'hF, 0, 0, 0, 0, 0, 0, 1'b0);
    run_txn(1'b0, 32'h0000_0040, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 1'b0);

    // randomized traffic over a small window so reads hit earlier writes
    for (int i = 0; i < 60; i++) begin
      r_we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) r_addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
      else r_addr = AW'($urandom_range(0, 63)) << 2;
      run_txn(r_we, r_addr, $urandom, SW'($urandom_range(0, 15)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check("idle_quiet", bus_activity(), 7'b0000001);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
